muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-003 SHALL have port: start  input  1  request to launch an operation; accepted only in IDLE.
REQ-004 SHALL have port: op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port: a  input  32  rs operand (multiplicand/dividend).
REQ-006 SHALL have port: b  input  32  rt operand (multiplier/divisor).
REQ-007 SHALL have port: hi_wr  input  1  MTHI strobe.
REQ-008 SHALL have port: lo_wr  input  1  MTLO strobe.
REQ-009 SHALL have port: wdata  input  32  data for MTHI/MTLO.
REQ-010 SHALL have port: busy  output  1  operation in progress; the core stalls MFHI/MFLO/mul/div on it.
REQ-011 SHALL have port: done  output  1  single-cycle completion pulse.
REQ-012 SHALL have port: div_by_zero  output  1  qualifies done; divisor was zero.
REQ-013 SHALL have port: hi  output  32  HI register.
REQ-014 SHALL have port: lo  output  32  LO register.

Function
REQ-015 SHALL implement FSM states IDLE, ITER, FIXUP; the shared adder/subtractor SHALL be sequenced one step per cycle.
REQ-016 Accept edge E0: in IDLE with start=1, SHALL capture op, a, b and the operand signs; later input changes SHALL have no effect.
REQ-017 Signed ops SHALL operate on magnitudes (two's-complement abs, 32-bit wrap, so abs(0x80000000)=0x80000000 treated unsigned); unsigned ops use raw values.
REQ-018 ITER: SHALL run exactly 32 cycles (edges E1..E32) under a 5-bit counter 0..31; multiply = radix-2 shift-add into 64-bit accumulator; divide = restoring shift-subtract, one quotient bit per cycle.
REQ-019 FIXUP (edge E33): SHALL apply sign correction and write hi/lo; state returns to IDLE.
REQ-020 Multiply result: {hi,lo} = full 64-bit product; negate if signed and operand signs differ.
REQ-021 Divide result: lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0x00000000.
REQ-023 Divisor zero (DIV/DIVU) SHALL be detected at E0: skip ITER/FIXUP, hi/lo unchanged, done=1 and div_by_zero=1 for the cycle after E1, busy high only between E0 and E1.
REQ-024 busy SHALL be 1 from after E0 until after the completing edge (E33, or E1 for divide-by-zero), else 0.
REQ-025 done SHALL be 1 for exactly the one cycle following the completing edge; div_by_zero SHALL be 0 whenever done=0 or divisor nonzero.
REQ-026 start while busy SHALL be ignored (no queuing).
REQ-027 hi_wr/lo_wr in IDLE SHALL load wdata into hi/lo at that edge; while busy they SHALL be ignored.
REQ-028 Simultaneous start and hi_wr/lo_wr in IDLE: the write SHALL take effect at E0; the operation result overwrites at completion.
REQ-029 A start in the done cycle (state IDLE) SHALL be accepted normally, giving back-to-back operations.

Reset
REQ-030 reset=1 at any edge SHALL force IDLE, counter 0, busy=0, done=0, div_by_zero=0, hi=0, lo=0; reset has priority over start and hi_wr/lo_wr.
REQ-031 Reset mid-operation SHALL abandon the operation with no result written and no done pulse.

Verification
REQ-032 MULT a=0xFFFFFFFD (-3), b=5 -> done exactly one cycle after E33, hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy high for 33 cycles.
REQ-033 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-035 MTHI 0x1234, MTLO 0x5678, then DIVU a=7, b=0 -> done and div_by_zero after E1, hi=0x1234, lo=0x5678 unchanged.
REQ-036 MULTU 8*15 with reset asserted at iteration 10 -> busy=0 next cycle, hi=lo=0, no done pulse; new start then completes with lo=0x78.
REQ-037 DIVU 100/7, second start with a different op held through busy -> only first result (lo=14, hi=2) produced, single done pulse.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential MIPS-style multiply/divide unit with HI/LO registers.
// A single 33-bit adder/subtractor is reused for 32 iterations of either
// radix-2 shift-add multiply or restoring shift-subtract divide, followed
// by one fixup cycle that applies sign correction and commits HI/LO.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, ITER, FIXUP} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg;
  // Multiply: {partial product high, multiplier/product low}.
  // Divide:   {partial remainder, dividend/quotient}.
  logic [63:0] acc_reg;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [31:0] opnd_reg;
  logic        is_div_reg;
  logic        neg_q_reg;   // negate product (mult) or quotient (div)
  logic        neg_r_reg;   // negate remainder (signed div, negative dividend)
  logic        dbz_reg;     // operation was launched with a zero divisor
  logic        done_reg;
  logic        dbz_out_reg;
  logic [31:0] hi_reg, lo_reg;

  // Operand decode at the accept edge.
  logic        op_div, op_signed, a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag;

  assign op_div    = op[1];
  assign op_signed = ~op[0];
  assign a_neg     = op_signed & a[31];
  assign b_neg     = op_signed & b[31];
  // Two's-complement abs wraps: 0x80000000 stays 0x80000000, read unsigned.
  assign a_mag     = a_neg ? (~a + 32'd1) : a;
  assign b_mag     = b_neg ? (~b + 32'd1) : b;
  assign b_zero    = (b == 32'd0);

  // Shared adder: multiply adds the multiplicand into the high half,
  // divide subtracts the divisor from the left-shifted partial remainder.
  logic [32:0] add_x, add_y;
  logic [33:0] add_sum;
  logic        div_ge;
  logic [63:0] iter_acc;

  // One iteration step of whichever algorithm is active.
  always_comb begin
    add_x    = 33'd0;
    add_y    = 33'd0;
    iter_acc = acc_reg;
    if (is_div_reg) begin
      add_x = acc_reg[63:31];
      add_y = ~{1'b0, opnd_reg};
    end else begin
      add_x = {1'b0, acc_reg[63:32]};
      add_y = acc_reg[0] ? {1'b0, opnd_reg} : 33'd0;
    end
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {33'd0, is_div_reg};
    // Carry out of x + ~d + 1 means the shifted remainder is >= divisor.
    div_ge  = add_sum[33];
    if (is_div_reg) begin
      if (div_ge)
        iter_acc = {add_sum[31:0], acc_reg[30:0], 1'b1};
      else
        iter_acc = {acc_reg[62:31], acc_reg[30:0], 1'b0};
    end else begin
      iter_acc = {add_sum[32:0], acc_reg[31:1]};
    end
  end

  // Sign correction applied in the fixup cycle.
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, res_hi, res_lo;

  // Select the committed HI/LO values for the finished operation.
  always_comb begin
    prod_fix = neg_q_reg ? (~acc_reg + 64'd1) : acc_reg;
    quo_fix  = neg_q_reg ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
    rem_fix  = neg_r_reg ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];
    if (is_div_reg) begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end else begin
      res_hi = prod_fix[63:32];
      res_lo = prod_fix[31:0];
    end
  end

  // Next-state logic: a zero divisor jumps straight to the completion cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = (op_div && b_zero) ? FIXUP : ITER;
      ITER:  if (cnt_reg == 5'd31) state_next = FIXUP;
      FIXUP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Datapath, HI/LO and completion flags; reset overrides every other action.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= 5'd0;
      acc_reg     <= 64'd0;
      opnd_reg    <= 32'd0;
      is_div_reg  <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      dbz_reg     <= 1'b0;
      done_reg    <= 1'b0;
      dbz_out_reg <= 1'b0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
    end else begin
      done_reg    <= 1'b0;
      dbz_out_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (hi_wr) hi_reg <= wdata;
          if (lo_wr) lo_reg <= wdata;
          if (start) begin
            cnt_reg    <= 5'd0;
            is_div_reg <= op_div;
            dbz_reg    <= op_div & b_zero;
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            acc_reg    <= {32'd0, (op_div ? a_mag : b_mag)};
            opnd_reg   <= op_div ? b_mag : a_mag;
          end
        end
        ITER: begin
          acc_reg <= iter_acc;
          cnt_reg <= cnt_reg + 5'd1;
        end
        FIXUP: begin
          done_reg    <= 1'b1;
          dbz_out_reg <= dbz_reg;
          if (!dbz_reg) begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign div_by_zero = dbz_out_reg;
  assign hi          = hi_reg;
  assign lo          = lo_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq with hand-computed expected results.
module tb_muldiv_seq;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        reset, start, hi_wr, lo_wr;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an operation for one edge, then scramble inputs so only the
  // captured values can matter.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
  endtask

  // Count cycles with busy high, bounded so a stuck design still terminates.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int exp_busy, input logic exp_dbz,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    start_op(o, x, y);
    wait_idle(n);
    chk({tag, ".busy_cycles"}, n, exp_busy);
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    chk({tag, ".dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
    chk({tag, ".hi"}, hi, exp_hi);
    chk({tag, ".lo"}, lo, exp_lo);
    $display("op %s a=%h b=%h -> hi=%h lo=%h busy=%0d", tag, x, y, hi, lo, n);
    @(negedge clk);
    chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, ".dbz_clear"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  initial begin
    int n;
    int dcount;
    reset = 1'b1; start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    op = 2'b00; a = 32'd0; b = 32'd0; wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst.hi", hi, 32'd0);
    chk("rst.lo", lo, 32'd0);
    $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    reset = 1'b0;

    // MTHI / MTLO
    @(negedge clk); hi_wr = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk); hi_wr = 1'b0; lo_wr = 1'b1; wdata = 32'h0000_5678;
    chk("mthi", hi, 32'h0000_1234);
    @(negedge clk); lo_wr = 1'b0;
    chk("mtlo", lo, 32'h0000_5678);
    $display("mthi/mtlo: hi=%h lo=%h", hi, lo);

    do_op("divu_by0",  DIVU,  32'd7,        32'd0,        1,  1'b1, 32'h0000_1234, 32'h0000_5678);
    do_op("mult_m3x5", MULT,  32'hFFFF_FFFD, 32'd5,       33, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    do_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("mult_min2", MULT,  32'h8000_0000, 32'h8000_0000, 33, 1'b0, 32'h4000_0000, 32'h0000_0000);
    do_op("mult_pxm1", MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001);
    do_op("div_m7d2",  DIV,   32'hFFFF_FFF9, 32'd2,       33, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu_7d2",  DIVU,  32'd7,        32'd2,        33, 1'b0, 32'h0000_0001, 32'h0000_0003);
    do_op("div_7dm2",  DIV,   32'd7,        32'hFFFF_FFFE, 33, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD);
    do_op("div_m100dm7", DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 1'b0, 32'hFFFF_FFFE, 32'h0000_000E);
    do_op("div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b0, 32'h0000_0000, 32'h8000_0000);
    do_op("div_by0",   DIV,   32'h8000_0000, 32'd0,       1,  1'b1, 32'h0000_0000, 32'h8000_0000);

    // HI/LO writes while busy are ignored; result overwrites afterwards.
    start_op(MULTU, 32'd3, 32'd4);
    hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk); hi_wr = 1'b0; lo_wr = 1'b0;
    chk("busywr.hi", hi, 32'h0000_0000);
    chk("busywr.lo", lo, 32'h8000_0000);
    wait_idle(n);
    chk("busywr.res_lo", lo, 32'h0000_000C);
    chk("busywr.res_hi", hi, 32'h0000_0000);
    $display("busy write: hi=%h lo=%h", hi, lo);

    // Start together with MTHI: write lands at accept, zero divisor keeps it.
    @(negedge clk);
    start = 1'b1; op = DIVU; a = 32'd7; b = 32'd0; hi_wr = 1'b1; wdata = 32'h0000_AAAA;
    @(negedge clk);
    start = 1'b0; hi_wr = 1'b0;
    wait_idle(n);
    chk("startwr.hi", hi, 32'h0000_AAAA);
    chk("startwr.lo", lo, 32'h0000_000C);
    chk("startwr.dbz", {31'd0, div_by_zero}, 32'd1);
    $display("start+mthi: hi=%h lo=%h dbz=%b", hi, lo, div_by_zero);

    // Reset in the middle of an iteration abandons the operation.
    start_op(MULTU, 32'd8, 32'd15);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst.busy", {31'd0, busy}, 32'd0);
    chk("midrst.hi", hi, 32'd0);
    chk("midrst.lo", lo, 32'd0);
    chk("midrst.done", {31'd0, done}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("midrst.quiet", dcount, 0);
    $display("mid reset: busy=%b hi=%h lo=%h", busy, hi, lo);
    do_op("multu_8x15", MULTU, 32'd8, 32'd15, 33, 1'b0, 32'h0000_0000, 32'h0000_0078);

    // Start held high with a different op through busy: no queuing.
    @(negedge clk);
    start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    op = MULT; a = 32'd5; b = 32'd6;
    wait_idle(n);
    start = 1'b0;
    chk("held.busy_cycles", n, 33);
    chk("held.done", {31'd0, done}, 32'd1);
    chk("held.lo", lo, 32'd14);
    chk("held.hi", hi, 32'd2);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("held.single_done", dcount, 0);
    $display("held start: hi=%h lo=%h busy=%0d", hi, lo, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
